aes_subbytes_seq: RTL and testbench
===================================

AES_SUBBYTES_SEQ -- requirements
Module: aes_subbytes_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept a state this cycle.
REQ-005 SHALL have port in_data, input, 128 bits: AES state; byte i = in_data[127-8i -: 8], i = row + 4*col.
REQ-006 SHALL have port sbox_a, output, 8 bits: address to the external registered 1-cycle S-box.
REQ-007 SHALL have port sbox_q, input, 8 bits: S-box result, valid one clock after sbox_a.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data holds a finished result.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-010 SHALL have port out_data, output, 128 bits: substituted state, same byte ordering as in_data.
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-012 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE; a transfer occurs on a clock edge with in_valid & in_ready.
REQ-014 On transfer SHALL latch in_data, clear the 4-bit issue counter, and enter RUN.
REQ-015 In RUN SHALL drive sbox_a = latched byte[cnt] combinationally and increment cnt every cycle; the cycle with cnt=15 transitions to DRAIN.
REQ-016 In the cycle after byte k is issued, SHALL capture sbox_q into result byte k (k = 0..15); byte 15 is captured in DRAIN.
REQ-017 After DRAIN SHALL enter DONE and assert out_valid; out_data and out_valid SHALL stay stable until out_ready.
REQ-018 The first cycle with out_valid=1 SHALL be exactly 18 cycles after the transfer cycle. The transfer cycle is cycle 0, RUN is cycles 1-16, DRAIN is cycle 17, and DONE starts in cycle 18.
REQ-019 In DONE with out_ready=1 SHALL return to IDLE on that edge; in_ready rises in the next cycle. Back-to-back throughput is one state per 19 cycles minimum.
REQ-020 SHALL ignore in_valid outside IDLE and out_ready outside DONE.
REQ-021 SHALL drive sbox_a = 8'h00 in IDLE, DRAIN and DONE.
REQ-022 The counter SHALL NOT wrap: the cnt=15 issue cycle always exits RUN.

Reset
REQ-023 Assertion of reset SHALL take effect without a clock edge, at any time including mid-RUN or in DONE, and SHALL force IDLE, cnt=0, latched state and result = 0, out_valid=0, busy=0, in_ready=1 after release, and sbox_a=0.
REQ-024 After reset, partially captured results SHALL be discarded and never presented on out_data.

Configuration
REQ-025 With macro AES_SUBBYTES_SHIFTROWS_EN defined, the block SHALL also apply ShiftRows: out byte (r+4c) = S(in byte (r+4((c+r) mod 4))). This SHALL be done by permuting the issue order, with no added latency.
REQ-026 Without AES_SUBBYTES_SHIFTROWS_EN, out byte i SHALL equal S(in byte i). Latency and handshake SHALL be identical in both builds.

Verification
REQ-027 Reset, then in_data = all 00 with a reference S-box attached -> out_data = 16 x 63 at cycle 18, in both builds.
REQ-028 in_data = 193de3bea0f4e22b9ac68d2ae9f84808 -> out_data = d42711aee0bf98f1b8b45de51e415230 without the macro, and d4bf5d30e0b452aeb84111f11e2798e5 with the macro.
REQ-029 Hold out_ready=0 for 10 cycles after out_valid -> out_valid and out_data stay stable and in_ready=0. Then raise out_ready for 1 cycle -> IDLE follows, and a second state is accepted on the next in_valid.
REQ-030 Assert reset asynchronously (mid-cycle) during RUN at cnt=7 -> outputs take their reset values immediately; no out_valid follows; a new state issued afterwards produces the correct result.
REQ-031 Toggle in_valid during RUN/DONE -> no second capture. The result matches the first input, and sbox_a follows the byte sequence 0..15 (or the permuted sequence with the macro).

Source files
------------

// File: rtl/aes_subbytes_seq.sv
// Sequential AES SubBytes: streams 16 state bytes through an external 1-cycle S-box.
// Define AES_SUBBYTES_SHIFTROWS_EN to fold ShiftRows into the byte issue order.
module aes_subbytes_seq (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [7:0]   sbox_a,
  input  logic [7:0]   sbox_q,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [7:0]  r_in  [16];
  logic [7:0]  r_res [16];
  logic [3:0]  w_src [16];
  logic        w_load;
  logic        w_cap;
  logic [3:0]  w_cap_idx;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_bytes
`ifdef AES_SUBBYTES_SHIFTROWS_EN
      // Result byte (r+4c) is sourced from input byte (r+4((c+r) mod 4)).
      assign w_src[gi] = 4'((gi % 4) + 4 * (((gi / 4) + (gi % 4)) % 4));
`else
      assign w_src[gi] = 4'(gi);
`endif
      assign out_data[127-8*gi -: 8] = r_res[gi];
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    sbox_a       = 8'h00;
    w_load       = 1'b0;
    w_cap        = 1'b0;
    w_cap_idx    = r_cnt - 4'd1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_load       = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        sbox_a = r_in[w_src[r_cnt]];
        // The S-box answer for the previous issue arrives now.
        w_cap  = (r_cnt != 4'd0);
        if (r_cnt == 4'd15) w_state_next = DRAIN;
      end
      DRAIN: begin
        w_cap        = 1'b1;
        w_cap_idx    = 4'd15;
        w_state_next = DONE;
      end
      DONE: begin
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      for (int i = 0; i < 16; i++) begin
        r_in[i]  <= 8'h00;
        r_res[i] <= 8'h00;
      end
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_cnt <= 4'd0;
        for (int i = 0; i < 16; i++) r_in[i] <= in_data[127-8*i -: 8];
      end else if (r_state == RUN && r_cnt != 4'd15) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_cap) r_res[w_cap_idx] <= sbox_q;
    end
  end

endmodule

// File: tb/tb_aes_subbytes_seq.sv
// Directed bench for aes_subbytes_seq with a behavioural registered AES S-box.
module tb_aes_subbytes_seq;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [7:0]   sbox_a;
  logic [7:0]   sbox_q = 8'h00;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;

  aes_subbytes_seq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .sbox_a(sbox_a), .sbox_q(sbox_q), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] sbox_tbl [256];
  always @(posedge clk) sbox_q <= sbox_tbl[sbox_a];

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
`ifdef AES_SUBBYTES_SHIFTROWS_EN
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
`else
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
`endif
  localparam logic [127:0] ZERO_OUT = {16{8'h63}};

  int n_vec = 0;
  int n_err = 0;
  int seq [16];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b  = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  function automatic logic [7:0] get_byte(input logic [127:0] d, input int i);
    return d[127-8*i -: 8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, r, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv; r = inv;
      for (int k = 0; k < 4; k++) begin
        r = rotl1(r);
        s = s ^ r;
      end
      sbox_tbl[x] = s ^ 8'h63;
    end
  endtask

  task automatic start_xfer(input logic [127:0] d);
    int t;
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (!in_ready) begin
      n_err++;
      $display("FAIL xfer_wait: in_ready=%0b, required 1 within 50 cycles", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Transfers d, checks the issue sequence, latency and result. Returns at the first
  // negedge with out_valid high (DONE not yet consumed).
  task automatic run_state(input string name, input logic [127:0] d,
                           input logic [127:0] exp, input bit toggle);
    int cyc;
    start_xfer(d);
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (toggle) begin
        in_valid = cyc[0];
        in_data  = ~d;
      end
      if (cyc <= 16) begin
        n_vec++;
        if (sbox_a !== get_byte(d, seq[cyc-1])) begin
          n_err++;
          $display("FAIL %s sbox_a cycle %0d: got %02h, required %02h",
                   name, cyc, sbox_a, get_byte(d, seq[cyc-1]));
        end
      end
      if (cyc == 5) begin
        n_vec++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
          n_err++;
          $display("FAIL %s run_flags: in_ready=%0b busy=%0b, required 0/1", name, in_ready, busy);
        end
      end
      if (cyc == 17) begin
        n_vec++;
        if (sbox_a !== 8'h00) begin
          n_err++;
          $display("FAIL %s drain_sbox_a: got %02h, required 00", name, sbox_a);
        end
      end
      if (out_valid === 1'b1) break;
    end
    n_vec++;
    if (cyc != 18) begin
      n_err++;
      $display("FAIL %s latency: got %0d cycles, required 18", name, cyc);
    end
    n_vec++;
    if (out_data !== exp) begin
      n_err++;
      $display("FAIL %s out_data: got %032h, required %032h", name, out_data, exp);
    end
    if (toggle) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        in_valid = ~in_valid;
      end
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        n_err++;
        $display("FAIL %s done_toggle: out_valid=%0b out_data=%032h, required 1/%032h",
                 name, out_valid, out_data, exp);
      end
      in_valid = 1'b0;
    end
    $display("%s: in=%032h out=%032h latency=%0d", name, d, out_data, cyc);
  endtask

  task automatic release_out(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s release: in_ready=%0b out_valid=%0b busy=%0b, required 1/0/0",
               name, in_ready, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        sbox_a !== 8'h00 || out_data !== 128'h0) begin
      n_err++;
      $display("FAIL reset_state: in_ready=%0b out_valid=%0b busy=%0b sbox_a=%02h out_data=%032h, required 1/0/0/00/0",
               in_ready, out_valid, busy, sbox_a, out_data);
    end
    reset = 1'b0;
    $display("reset: released");
  endtask

  task automatic test_zero();
    run_state("zero", 128'h0, ZERO_OUT, 1'b0);
    release_out("zero");
  endtask

  task automatic test_ignore_valid();
    run_state("toggle", FIPS_IN, FIPS_OUT, 1'b1);
    release_out("toggle");
  endtask

  task automatic test_back_to_back();
    run_state("hold", FIPS_IN, FIPS_OUT, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== FIPS_OUT || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL hold cycle %0d: out_valid=%0b in_ready=%0b out_data=%032h, required 1/0/%032h",
                 k, out_valid, in_ready, out_data, FIPS_OUT);
      end
    end
    release_out("hold");
    run_state("second", 128'h0, ZERO_OUT, 1'b0);
    release_out("second");
  endtask

  task automatic test_async_reset();
    bit seen;
    start_xfer(FIPS_IN);
    repeat (8) @(negedge clk);
    n_vec++;
    if (sbox_a !== get_byte(FIPS_IN, seq[7])) begin
      n_err++;
      $display("FAIL areset_pre: sbox_a=%02h, required %02h", sbox_a, get_byte(FIPS_IN, seq[7]));
    end
    #1 reset = 1'b1;
    #1;
    n_vec++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || sbox_a !== 8'h00 ||
        out_data !== 128'h0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL areset_now: busy=%0b out_valid=%0b sbox_a=%02h in_ready=%0b out_data=%032h, required 0/0/00/1/0",
               busy, out_valid, sbox_a, in_ready, out_data);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (seen) begin
      n_err++;
      $display("FAIL areset_quiet: out_valid/busy seen=%0b, required 0", seen);
    end
    $display("areset: mid-RUN reset at cnt=7 applied");
    run_state("post_reset", FIPS_IN, FIPS_OUT, 1'b0);
    release_out("post_reset");
  endtask

  initial begin
`ifdef AES_SUBBYTES_SHIFTROWS_EN
    seq = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};
`else
    seq = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif
    build_sbox();
    test_reset();
    test_zero();
    test_ignore_valid();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
